stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control and sequencing block for the mm:ss BCD stopwatch counter datapath.
- Conditions the raw SEL/ADJ switches and the PAUSE/CLR buttons, and runs the RUN/PAUSED/ADJ_SEC/ADJ_MIN mode FSM.
- Generates single-cycle increment/clear strobes at 1 Hz (normal) or 2 Hz (adjust), plus blink-blank enables for the display driver.
- The counter datapath and the segment driver consume its outputs; it owns no digit state.

Parameters:
- DIV_1HZ, 100000000, clk cycles per normal-mode increment.
- DIV_2HZ, 50000000, clk cycles per adjust-mode increment.
- DIV_BLINK, 25000000, clk cycles per blink-phase toggle.
- DB_CYCLES, 1000000, consecutive stable synchronized cycles required before a debounced level changes.

Ports:
- clk  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- SEL  in  1  raw switch; 0 = adjust seconds, 1 = adjust minutes.
- ADJ  in  1  raw switch; 1 = adjust mode.
- PAUSE  in  1  raw button; each press toggles run/pause.
- CLR  in  1  raw button; each press zeroes the counter.
- inc_sec  out  1  one-cycle strobe: increment seconds.
- inc_min  out  1  one-cycle strobe: increment minutes only.
- carry_en  out  1  seconds wrap 59->00 carries into minutes.
- clr  out  1  one-cycle strobe: zero all digits.
- mode  out  2  current FSM state encoding.
- paused  out  1  pause flag.
- blank_sec  out  1  blank the seconds digits this cycle.
- blank_min  out  1  blank the minutes digits this cycle.

Behaviour:
- Reset (RESET=1 at posedge):
  - all outputs 0, state RUN, pause flag 0.
  - all divider, blink and debounce counters 0; synchronizers and debounced levels 0.
- Input conditioning: every raw input passes through a 2-FF synchronizer, then a debouncer.
  - Debounced level updates once the synchronized value has differed from it for DB_CYCLES consecutive cycles; any bounce restarts that count.
  - Rise pulse is 1 cycle, on the cycle the debounced level goes 0->1.
- Mode FSM, evaluated every cycle on debounced levels:
  - ADJ=1 and SEL=0 -> ADJ_SEC; ADJ=1 and SEL=1 -> ADJ_MIN, from any state.
  - ADJ=0 -> PAUSED if the pause flag is set, else RUN.
  - The PAUSE rise pulse toggles the pause flag in RUN/PAUSED only. It is ignored in the adjust states, and the flag is preserved across adjust.
- Encoding: mode = 0 RUN, 1 PAUSED, 2 ADJ_SEC, 3 ADJ_MIN. paused = pause flag.
- carry_en = 1 in RUN only.
- 1 Hz divider:
  - counts only in RUN; held at 0 in every other state.
  - at count DIV_1HZ-1 it wraps to 0 and asserts inc_sec for 1 cycle.
  - first strobe after entering RUN comes exactly DIV_1HZ cycles after entry.
- 2 Hz divider:
  - counts only in ADJ_SEC/ADJ_MIN; cleared on any state change.
  - at count DIV_2HZ-1 it wraps and asserts inc_sec (ADJ_SEC) or inc_min (ADJ_MIN).
  - carry_en=0 there, so the datapath wraps seconds 59->00 without a minute carry.
- Mutual exclusion: inc_sec and inc_min are never high together.
- CLR:
  - rise pulse -> clr=1 for exactly 1 cycle, in any state.
  - same cycle: inc_sec/inc_min are forced 0 and the active divider is cleared to 0.
  - state and pause flag are unchanged.
- Blink:
  - phase counter runs only in the adjust states; phase toggles every DIV_BLINK cycles.
  - counter and phase are cleared to 0 outside adjust and on any state change.
  - blank_sec = ADJ_SEC & phase; blank_min = ADJ_MIN & phase.
- Outputs are registered. A strobe appears the cycle after its divider reaches terminal count; same rule for clr after the rise pulse.
- Divider widths are clog2 of the parameter. Parameters must be >=2; smaller values are illegal.
- RESET mid-operation overrides everything and takes effect the same edge.

Decomposition:
- Package stopwatch_pkg holds:
  - mode encodings MODE_RUN, MODE_PAUSED, MODE_ADJ_SEC, MODE_ADJ_MIN;
  - default divider constants.
- One sub-module, btn_debounce (2-FF sync + stable counter + rise-pulse output), instantiated four times (SEL, ADJ, PAUSE, CLR).
- Dividers and FSM stay in stopwatch_ctrl.

Test Plan (DIV_1HZ=10, DIV_2HZ=5, DIV_BLINK=4, DB_CYCLES=3):
- RESET then idle 40 cycles -> mode=0, paused=0, carry_en=1; inc_sec pulses every 10 cycles; exactly 4 pulses, inc_min never high.
- PAUSE press held 10 cycles -> one toggle; paused=1, mode=1, no strobes. Second press -> mode=0; first inc_sec arrives 10 cycles after the state change.
- ADJ=1, SEL=0 -> mode=2, carry_en=0, inc_sec every 5 cycles, blank_sec toggles every 4 cycles. Set SEL=1 -> mode=3; strobes move to inc_min, and the divider and phase restart at 0.
- While paused, ADJ 1 then 0 -> returns to mode=1 with paused=1; PAUSE presses during adjust cause no change.
- Raw PAUSE bouncing 1,0,1,0 at 1-cycle spacing, then stable 1 -> exactly one toggle, no earlier than 3 stable synchronized cycles.
- CLR press timed so its rise pulse coincides with the inc_sec terminal count -> clr=1 for 1 cycle, no inc_sec that cycle, next inc_sec 10 cycles later. RESET mid-count -> all outputs 0 next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared mode encodings and default timing constants for the stopwatch control slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_PAUSED  = 2'd1,
    MODE_ADJ_SEC = 2'd2,
    MODE_ADJ_MIN = 2'd3
  } mode_e;

  localparam int unsigned DEF_DIV_1HZ   = 100000000;
  localparam int unsigned DEF_DIV_2HZ   = 50000000;
  localparam int unsigned DEF_DIV_BLINK = 25000000;
  localparam int unsigned DEF_DB_CYCLES = 1000000;

  function automatic logic is_adjust(mode_e m);
    return (m == MODE_ADJ_SEC) || (m == MODE_ADJ_MIN);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Two-flop synchronizer, stable-count debouncer and 0->1 rise pulse for one raw input.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic RESET,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronized input disagrees with the level;
  // any agreement (a bounce back) restarts the count.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM, 1 Hz / 2 Hz strobe dividers, clear strobe and blink enables.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV_1HZ   = DEF_DIV_1HZ,
  parameter int unsigned DIV_2HZ   = DEF_DIV_2HZ,
  parameter int unsigned DIV_BLINK = DEF_DIV_BLINK,
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       SEL,
  input  logic       ADJ,
  input  logic       PAUSE,
  input  logic       CLR,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       carry_en,
  output logic       clr,
  output logic [1:0] mode,
  output logic       paused,
  output logic       blank_sec,
  output logic       blank_min
);

  localparam int unsigned W1 = $clog2(DIV_1HZ);
  localparam int unsigned W2 = $clog2(DIV_2HZ);
  localparam int unsigned WB = $clog2(DIV_BLINK);

  logic sel_lvl, sel_rise;
  logic adj_lvl, adj_rise;
  logic pause_lvl, pause_rise;
  logic clr_lvl, clr_rise;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
    .clk   (clk),
    .RESET (RESET),
    .din   (SEL),
    .level (sel_lvl),
    .rise  (sel_rise)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_adj (
    .clk   (clk),
    .RESET (RESET),
    .din   (ADJ),
    .level (adj_lvl),
    .rise  (adj_rise)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk   (clk),
    .RESET (RESET),
    .din   (PAUSE),
    .level (pause_lvl),
    .rise  (pause_rise)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk   (clk),
    .RESET (RESET),
    .din   (CLR),
    .level (clr_lvl),
    .rise  (clr_rise)
  );

  // Switches are used as levels, buttons as edges; the other halves are spare.
  logic unused_db;
  assign unused_db = ^{sel_rise, adj_rise, pause_lvl, clr_lvl};

  mode_e   state_q, state_d;
  logic    pause_q, pause_d;
  logic    stable;

  logic [W1-1:0] div1_q, div1_d;
  logic [W2-1:0] div2_q, div2_d;
  logic [WB-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  logic inc_sec_q, inc_sec_d;
  logic inc_min_q, inc_min_d;
  logic carry_q, clr_q;
  logic blank_sec_q, blank_min_q;

  always_comb begin
    pause_d = pause_q;
    state_d = state_q;
    if (((state_q == MODE_RUN) || (state_q == MODE_PAUSED)) && pause_rise) begin
      pause_d = ~pause_q;
    end
    if (adj_lvl) begin
      state_d = sel_lvl ? MODE_ADJ_MIN : MODE_ADJ_SEC;
    end else begin
      state_d = pause_d ? MODE_PAUSED : MODE_RUN;
    end
  end

  assign stable = (state_d == state_q);

  // Dividers restart from zero on every state change and on a clear press.
  always_comb begin
    div1_d    = '0;
    div2_d    = '0;
    inc_sec_d = 1'b0;
    inc_min_d = 1'b0;
    if (stable && !clr_rise) begin
      if (state_q == MODE_RUN) begin
        if (div1_q == W1'(DIV_1HZ - 1)) begin
          inc_sec_d = 1'b1;
        end else begin
          div1_d = div1_q + 1'b1;
        end
      end else if (is_adjust(state_q)) begin
        if (div2_q == W2'(DIV_2HZ - 1)) begin
          inc_sec_d = (state_q == MODE_ADJ_SEC);
          inc_min_d = (state_q == MODE_ADJ_MIN);
        end else begin
          div2_d = div2_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bcnt_d  = '0;
    phase_d = 1'b0;
    if (stable && is_adjust(state_q)) begin
      if (bcnt_q == WB'(DIV_BLINK - 1)) begin
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= MODE_RUN;
      pause_q     <= 1'b0;
      div1_q      <= '0;
      div2_q      <= '0;
      bcnt_q      <= '0;
      phase_q     <= 1'b0;
      inc_sec_q   <= 1'b0;
      inc_min_q   <= 1'b0;
      carry_q     <= 1'b0;
      clr_q       <= 1'b0;
      blank_sec_q <= 1'b0;
      blank_min_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pause_q     <= pause_d;
      div1_q      <= div1_d;
      div2_q      <= div2_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      inc_sec_q   <= inc_sec_d;
      inc_min_q   <= inc_min_d;
      carry_q     <= (state_d == MODE_RUN);
      clr_q       <= clr_rise;
      blank_sec_q <= (state_d == MODE_ADJ_SEC) & phase_d;
      blank_min_q <= (state_d == MODE_ADJ_MIN) & phase_d;
    end
  end

  assign inc_sec   = inc_sec_q;
  assign inc_min   = inc_min_q;
  assign carry_en  = carry_q;
  assign clr       = clr_q;
  assign mode      = state_q;
  assign paused    = pause_q;
  assign blank_sec = blank_sec_q;
  assign blank_min = blank_min_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench: a timeline-based reference model predicts every output cycle.
module tb_stopwatch_ctrl;

  localparam int unsigned DIV_1HZ   = 10;
  localparam int unsigned DIV_2HZ   = 5;
  localparam int unsigned DIV_BLINK = 4;
  localparam int unsigned DB_CYCLES = 3;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       SEL = 1'b0, ADJ = 1'b0, PAUSE = 1'b0, CLR = 1'b0;
  logic       inc_sec, inc_min, carry_en, clr, paused, blank_sec, blank_min;
  logic [1:0] mode;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DIV_1HZ   (DIV_1HZ),
    .DIV_2HZ   (DIV_2HZ),
    .DIV_BLINK (DIV_BLINK),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .SEL       (SEL),
    .ADJ       (ADJ),
    .PAUSE     (PAUSE),
    .CLR       (CLR),
    .inc_sec   (inc_sec),
    .inc_min   (inc_min),
    .carry_en  (carry_en),
    .clr       (clr),
    .mode      (mode),
    .paused    (paused),
    .blank_sec (blank_sec),
    .blank_min (blank_min)
  );

  typedef struct packed {
    logic       inc_sec;
    logic       inc_min;
    logic       carry_en;
    logic       clr;
    logic [1:0] mode;
    logic       paused;
    logic       blank_sec;
    logic       blank_min;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: raw-sample history (index k = k+1 cycles old), debounced
  // levels, mode, pause flag and the cycle at which each timebase last restarted.
  bit   hist [4][DB_CYCLES+1];
  bit   lvl  [4];
  bit   rse  [4];
  bit   raw  [4];
  int   m_st, m_pst, m_pause, t_div, t_blink, n_cyc;

  initial begin : model
    obs_t e;
    bit   all_diff;
    int   phase;
    n_cyc = 0;
    m_st = 0;
    m_pause = 0;
    t_div = 0;
    t_blink = 0;
    forever begin
      @(posedge clk);
      n_cyc++;
      raw[0] = SEL;
      raw[1] = ADJ;
      raw[2] = PAUSE;
      raw[3] = CLR;
      e = '0;
      if (RESET) begin
        for (int i = 0; i < 4; i++) begin
          lvl[i] = 1'b0;
          rse[i] = 1'b0;
          for (int k = 0; k <= DB_CYCLES; k++) hist[i][k] = 1'b0;
        end
        m_st = 0;
        m_pause = 0;
        t_div = n_cyc;
        t_blink = n_cyc;
      end else begin
        m_pst = m_st;
        if (rse[2] && m_pst <= 1) m_pause = 1 - m_pause;
        if (lvl[1]) m_st = lvl[0] ? 3 : 2;
        else m_st = m_pause ? 1 : 0;
        e.clr = rse[3];
        if (m_st != m_pst) begin
          t_div = n_cyc;
          t_blink = n_cyc;
        end
        if (e.clr) t_div = n_cyc;
        if (m_st == m_pst && !e.clr) begin
          if (m_st == 0 && (n_cyc - t_div) % DIV_1HZ == 0) e.inc_sec = 1'b1;
          if (m_st == 2 && (n_cyc - t_div) % DIV_2HZ == 0) e.inc_sec = 1'b1;
          if (m_st == 3 && (n_cyc - t_div) % DIV_2HZ == 0) e.inc_min = 1'b1;
        end
        phase = (m_st >= 2) ? ((n_cyc - t_blink) / DIV_BLINK) % 2 : 0;
        e.blank_sec = (m_st == 2) && (phase == 1);
        e.blank_min = (m_st == 3) && (phase == 1);
        e.carry_en  = (m_st == 0);
        e.mode      = 2'(m_st);
        e.paused    = (m_pause != 0);
        // Level flips once the last DB_CYCLES synchronized samples all disagree with it.
        for (int i = 0; i < 4; i++) begin
          all_diff = 1'b1;
          for (int k = 1; k <= DB_CYCLES; k++) if (hist[i][k] == lvl[i]) all_diff = 1'b0;
          rse[i] = all_diff && !lvl[i];
          if (all_diff) lvl[i] = !lvl[i];
        end
      end
      for (int i = 0; i < 4; i++) begin
        for (int k = DB_CYCLES; k >= 1; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = RESET ? 1'b0 : raw[i];
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{inc_sec, inc_min, carry_en, clr, mode, paused, blank_sec, blank_min};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs @%0t: got %b required %b (inc_sec inc_min carry clr mode paused bs bm)",
                   $time, a, e);
        end
        tests++;
        if (inc_sec && inc_min) begin
          fails++;
          $display("FAIL strobe_excl @%0t: inc_sec=%b inc_min=%b, required not both", $time,
                   inc_sec, inc_min);
        end
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press_pause(input int hold, input int gap);
    PAUSE = 1'b1;
    idle(hold);
    PAUSE = 1'b0;
    idle(gap);
  endtask

  initial begin : stimulus
    int n_sec, n_min;
    RESET = 1'b1;
    idle(3);
    RESET = 1'b0;
    n_sec = 0;
    n_min = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_sec += int'(inc_sec);
      n_min += int'(inc_min);
    end
    tests++;
    if (n_sec != 4) begin
      fails++;
      $display("FAIL idle_inc_sec_count: got %0d required 4", n_sec);
    end
    tests++;
    if (n_min != 0) begin
      fails++;
      $display("FAIL idle_inc_min_count: got %0d required 0", n_min);
    end

    press_pause(10, 20);
    press_pause(10, 30);

    ADJ = 1'b1;
    SEL = 1'b0;
    idle(30);
    SEL = 1'b1;
    idle(30);
    ADJ = 1'b0;
    idle(20);

    press_pause(8, 10);
    ADJ = 1'b1;
    idle(15);
    press_pause(8, 10);
    ADJ = 1'b0;
    idle(20);
    press_pause(8, 20);

    PAUSE = 1'b1; idle(1);
    PAUSE = 1'b0; idle(1);
    PAUSE = 1'b1; idle(1);
    PAUSE = 1'b0; idle(1);
    PAUSE = 1'b1; idle(10);
    PAUSE = 1'b0; idle(20);

    // Sweep press timing so one clear lands on a divider terminal count.
    for (int off = 0; off < 12; off++) begin
      CLR = 1'b1;
      idle(6);
      CLR = 1'b0;
      idle(6 + off);
    end

    idle(7);
    RESET = 1'b1;
    idle(1);
    RESET = 1'b0;
    idle(20);

    repeat (300) begin
      case ($urandom_range(0, 3))
        0: SEL = ~SEL;
        1: ADJ = ~ADJ;
        2: PAUSE = ~PAUSE;
        default: CLR = ~CLR;
      endcase
      idle(int'($urandom_range(1, 12)));
      if ($urandom_range(0, 49) == 0) begin
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
      end
    end

    idle(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
